regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of reg_file between NREQ writeback requesters (ALU, load unit, ...).
//  - Round-robin grant; accepted write registered into a one-entry output stage that drives wen/rd/wdata.
//  - Sits between the execute/memory writeback sources and reg_file.

---
 rtl/regfile_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single write port of reg_file between NREQ writeback requesters
// (ALU, load unit, ...). Round-robin arbitration picks at most one requester
// per cycle. The accepted write is registered into a one-entry output stage
// that drives reg_file's wen/rd/wdata during the following cycle.
//
// Parameters
//   NREQ  number of writeback requesters (2..8)
//   XLEN  data width
//   AW    register address width
//
// Ports
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   flush      in   1          synchronous; empties the output stage and
//                              blocks grants in this cycle
//   req_valid  in   NREQ       requester i has a write pending
//   req_rd     in   NREQ*AW    dest reg of requester i, slice [i*AW +: AW]
//   req_data   in   NREQ*XLEN  write data of requester i, slice [i*XLEN +: XLEN]
//   req_ready  out  NREQ       one-hot grant
//   rf_wen     out  1          reg_file write enable
//   rf_rd      out  AW         reg_file destination register
//   rf_wdata   out  XLEN       reg_file write data
//   busy       out  1          output stage holds a write (FSM state WRITE);
//                              this is also the FSM state observation point
//
// Optional feature (macro WB_BYPASS_EN):
//   byp_rs1   in   AW    read-port source register 1
//   byp_rs2   in   AW    read-port source register 2
//   byp_hit1  out  1     rs1 matches the write committing on this edge
//   byp_hit2  out  1     rs2 matches the write committing on this edge
//   byp_data  out  XLEN  forwarded data (rf_wdata)
//   With the macro undefined these ports and the forwarding logic are absent.
//
// Handshake: a transfer from requester i happens on a rising edge where
// req_valid[i] & req_ready[i] = 1. A requester holds valid/rd/data stable
// until it sees ready; ready is purely combinational from req_valid, the
// round-robin pointer, flush and rst_n, never from the output stage.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_rd,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]        byp_rs1,
  input  logic [AW-1:0]        byp_rs2,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [XLEN-1:0]      byp_data
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              rf_wen_q, rf_wen_d;
  logic [AW-1:0]     rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

  logic [NREQ-1:0]   grant;
  logic              grant_any;
  logic [PW-1:0]     grant_idx;
  logic [AW-1:0]     sel_rd;
  logic [XLEN-1:0]   sel_data;

  // Requester index visited at search offset k, wrapped modulo NREQ so that
  // non-power-of-two NREQ never produces an out-of-range candidate.
  function automatic logic [PW-1:0] rr_candidate(input logic [PW-1:0] base,
                                                 input int          k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NREQ) sum = sum - NREQ;
    return PW'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin grant. The search starts at rr_ptr and takes the first valid
  // requester. Holding reset or flush suppresses every grant so nothing is
  // accepted that the output stage would then have to discard.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    if (rst_n && !flush) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!grant_any && req_valid[rr_candidate(rr_ptr_q, k)]) begin
          grant_any = 1'b1;
          grant_idx = rr_candidate(rr_ptr_q, k);
        end
      end
      if (grant_any) grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign sel_rd    = req_rd[grant_idx*AW +: AW];
  assign sel_data  = req_data[grant_idx*XLEN +: XLEN];

  // ---------------------------------------------------------------------------
  // FSM next state and output-stage load. The stage drains every cycle since
  // reg_file consumes the write on the next edge, so rf_wen defaults to 0 and
  // is only raised by a fresh grant. rd/wdata hold when nothing is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rf_wen_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;

    case (state_q)
      S_IDLE:  if (grant_any)            state_d = S_WRITE;
      S_WRITE: if (flush || !grant_any)  state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase

    if (grant_any) begin
      // A write to x0 is accepted so the requester can retire, but it must
      // never reach reg_file; rd/wdata still load for observability.
      rf_wen_d   = (sel_rd != '0);
      rf_rd_d    = sel_rd;
      rf_wdata_d = sel_data;
      rr_ptr_d   = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = (state_q == S_WRITE);

`ifdef WB_BYPASS_EN
  // Forward the write that reg_file commits on the coming edge. x0 is never
  // forwarded since it always reads as zero.
  assign byp_hit1 = rf_wen_q && (rf_rd_q == byp_rs1) && (byp_rs1 != '0);
  assign byp_hit2 = rf_wen_q && (rf_rd_q == byp_rs2) && (byp_rs2 != '0);
  assign byp_data = rf_wdata_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Bench for regfile_wb_arbiter (NREQ=2, XLEN=32, AW=5). A behavioural model
// of the arbiter (pointer as an integer, search by modular arithmetic, output
// stage as plain variables) is stepped on every rising edge. Inputs change
// 1 time unit after a rising edge; combinational ready is checked before the
// next edge and registered outputs 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_wen;
  logic [AW-1:0]        rf_rd;
  logic [XLEN-1:0]      rf_wdata;
  logic                 busy;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]        byp_rs1;
  logic [AW-1:0]        byp_rs2;
  logic                 byp_hit1;
  logic                 byp_hit2;
  logic [XLEN-1:0]      byp_data;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int              m_ptr;
  logic            m_wen;
  logic            m_busy;
  logic [AW-1:0]   m_rd;
  logic [XLEN-1:0] m_data;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
`ifdef WB_BYPASS_EN
    ,
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data  (byp_data)
`endif
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v,
                                                  input int ptr,
                                                  input logic fl);
    logic [NREQ-1:0] g;
    bit found;
    g = '0;
    found = 0;
    if (!fl) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr + k) % NREQ;
        if (!found && v[i]) begin
          g[i] = 1'b1;
          found = 1;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_wen  = 1'b0;
    m_busy = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] g;
    g = model_grant(req_valid, m_ptr, flush);
    m_wen  = 1'b0;
    m_busy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) begin
        m_busy = 1'b1;
        m_rd   = req_rd[i*AW +: AW];
        m_data = req_data[i*XLEN +: XLEN];
        m_wen  = (m_rd != 0);
        m_ptr  = (i + 1) % NREQ;
      end
    end
  endtask

  // --------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
`ifdef WB_BYPASS_EN
    byp_rs1   = '0;
    byp_rs2   = '0;
`endif
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd,
                         input logic [XLEN-1:0] data);
    req_valid[i]              = 1'b1;
    req_rd[i*AW +: AW]        = rd;
    req_data[i*XLEN +: XLEN]  = data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    req_valid = 2'b11;
    #3;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    checks++;
    if (rf_wen !== 1'b0 || busy !== 1'b0 || rf_rd !== '0 || rf_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wen=%b busy=%b rd=%0d wdata=%h want all 0",
               rf_wen, busy, rf_rd, rf_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1;
    // Get a write into the output stage, then reset in the middle of it.
    set_req(0, 5'd7, 32'hAAAA_0001);
    tick();
    req_valid = '0;
    checks++;
    if (rf_wen !== 1'b1) begin
      errors++; $display("FAIL reset_prewrite_wen: got %b want 1", rf_wen);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rf_wen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: wen=%b busy=%b want 0 0", rf_wen, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_ptr_zero: ready=%b want 01", req_ready);
    end
    req_valid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    idle_inputs();
    set_req(0, 5'd5, 32'h3);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL single_ready: got %b want 01", req_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (rf_wen !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'h3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_out: wen=%b rd=%0d wdata=%h busy=%b want 1 5 3 1",
               rf_wen, rf_rd, rf_wdata, busy);
    end
    tick();
    checks++;
    if (rf_wen !== 1'b0 || busy !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'h3) begin
      errors++;
      $display("FAIL single_drain: wen=%b busy=%b rd=%0d wdata=%h want 0 0 5 3",
               rf_wen, busy, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_contention();
    logic [NREQ-1:0] exp_ready;
    logic [AW-1:0]   exp_rd;
    apply_reset();
    idle_inputs();
    set_req(0, 5'd3, 32'h1111_0000);
    set_req(1, 5'd9, 32'h2222_0000);
    for (int c = 0; c < 4; c++) begin
      exp_ready = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_rd    = (c % 2 == 0) ? 5'd3 : 5'd9;
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL contention_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
      end
      tick();
      checks++;
      if (rf_wen !== 1'b1 || rf_rd !== exp_rd) begin
        errors++;
        $display("FAIL contention_out[%0d]: wen=%b rd=%0d want 1 %0d",
                 c, rf_wen, rf_rd, exp_rd);
      end
    end
  endtask

  task automatic test_flush();
    // Still busy from contention, both requesters valid, pointer back at 0.
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL flush_ready: got %b want 00", req_ready);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (rf_wen !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_out: wen=%b busy=%b want 0 0", rf_wen, busy);
    end
    #1;
    checks++;
    if (req_ready !== model_grant(req_valid, m_ptr, 1'b0) || req_ready !== 2'b01) begin
      errors++; $display("FAIL flush_resume: ready=%b want 01", req_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (rf_wen !== 1'b1 || rf_rd !== 5'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_retry: wen=%b rd=%0d busy=%b want 1 3 1", rf_wen, rf_rd, busy);
    end
  endtask

  task automatic test_x0();
    idle_inputs();
    set_req(0, 5'd0, 32'hE0F);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL x0_ready: got %b want 01", req_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (rf_wen !== 1'b0 || busy !== 1'b1 || rf_rd !== 5'd0 || rf_wdata !== 32'hE0F) begin
      errors++;
      $display("FAIL x0_out: wen=%b busy=%b rd=%0d wdata=%h want 0 1 0 e0f",
               rf_wen, busy, rf_rd, rf_wdata);
    end
    tick();
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    idle_inputs();
    set_req(0, 5'd13, 32'hBEEF_0013);
    tick();
    idle_inputs();
    byp_rs1 = 5'd13;
    byp_rs2 = 5'd0;
    #1;
    checks++;
    if (byp_hit1 !== 1'b1 || byp_hit2 !== 1'b0 || byp_data !== 32'hBEEF_0013) begin
      errors++;
      $display("FAIL bypass_hit: hit1=%b hit2=%b data=%h want 1 0 beef0013",
               byp_hit1, byp_hit2, byp_data);
    end
    byp_rs1 = 5'd12;
    byp_rs2 = 5'd13;
    #1;
    checks++;
    if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b1) begin
      errors++;
      $display("FAIL bypass_swap: hit1=%b hit2=%b want 0 1", byp_hit1, byp_hit2);
    end
    tick();
    checks++;
    if (byp_hit2 !== 1'b0) begin
      errors++; $display("FAIL bypass_idle: hit2=%b want 0", byp_hit2);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic [NREQ-1:0] exp_g;
    idle_inputs();
    for (int c = 0; c < 300; c++) begin
      flush = ($urandom_range(0, 9) == 0);
      exp_g = model_grant(req_valid, m_ptr, flush);
      #1;
      checks++;
      if (req_ready !== exp_g) begin
        errors++;
        $display("FAIL random_ready[%0d]: got %b want %b", c, req_ready, exp_g);
      end
      tick();
      checks++;
      if (rf_wen !== m_wen || busy !== m_busy || rf_rd !== m_rd || rf_wdata !== m_data) begin
        errors++;
        $display("FAIL random_out[%0d]: wen=%b busy=%b rd=%0d wdata=%h want %b %b %0d %h",
                 c, rf_wen, busy, rf_rd, rf_wdata, m_wen, m_busy, m_rd, m_data);
      end
      // Requesters: a granted one may present a new write, an idle one may
      // start one, a waiting one holds everything stable.
      for (int i = 0; i < NREQ; i++) begin
        if (exp_g[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) != 0)
            set_req(i, AW'($urandom_range(0, 31)), $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_flush();
    test_x0();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
